// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: drives an external 4-bit adder one nibble per clock, LSB first, to form a 4*NIBBLES-bit sum.
// Optional macro NSA_SUB_EN adds a sub port for modular subtraction (B inverted, carry-in forced to 1).
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin_init,
`ifdef NSA_SUB_EN
  input  logic                 sub,
`endif
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_co,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout
);
  localparam int W  = 4*NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state;
  logic [W-1:0]   a_q, b_q, b_in;
  logic           carry, c_in, run;
  logic [IW-1:0]  idx;
`ifdef NSA_SUB_EN
  assign b_in = sub ? ~op_b : op_b;
  assign c_in = sub | cin_init;
`else
  assign b_in = op_b;
  assign c_in = cin_init;
`endif
  // adder inputs decode registered state only, so they are quiet outside RUN
  assign run     = state == RUN;
  assign add_a   = run ? a_q[4*idx +: 4] : 4'd0;
  assign add_b   = run ? b_q[4*idx +: 4] : 4'd0;
  assign add_cin = run & carry;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      result <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q    <= op_a;
          b_q    <= b_in;
          carry  <= c_in;
          idx    <= '0;
          result <= '0;
          cout   <= 1'b0;
          busy   <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          result[4*idx +: 4] <= add_s;
          carry              <= add_co;
          if (idx == IW'(NIBBLES-1)) begin
            cout  <= add_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else idx <= idx + 1'b1;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: scoreboard bench with a behavioural 4-bit adder and an arithmetic reference model.
module tb_nibble_serial_add_ctrl;
  localparam int N = 4;
  localparam int W = 4*N;
  logic clk = 0, rst = 0, start = 0, cin_init = 0;
  logic [W-1:0] op_a = 0, op_b = 0, result;
  logic [3:0] add_a, add_b, add_s;
  logic add_cin, add_co, busy, done, cout;
`ifdef NSA_SUB_EN
  logic sub = 0;
`endif
  typedef struct {logic [W-1:0] a; logic [W-1:0] b; logic c; logic s;} op_t;
  op_t q[$];
  int total = 0, passed = 0;

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin_init(cin_init),
`ifdef NSA_SUB_EN
    .sub(sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_co(add_co),
    .busy(busy), .done(done), .result(result), .cout(cout)
  );

  assign {add_co, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);
  always #5 clk = ~clk;

  task automatic chk(string name, logic [W:0] act, logic [W:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] beff(op_t o);
    return o.s ? ~o.b : o.b;
  endfunction
  function automatic logic [W:0] full_sum(op_t o);
    return {1'b0, o.a} + {1'b0, beff(o)} + (W+1)'(o.s | o.c);
  endfunction
  function automatic logic carry_into(op_t o, int k);
    logic [W:0] m, lo;
    m  = ((W+1)'(1) << (4*k)) - 1'b1;
    lo = ({1'b0, o.a} & m) + ({1'b0, beff(o)} & m) + (W+1)'(o.s | o.c);
    return lo[4*k];
  endfunction

  int k = 0;
  logic prev_done = 0;
  always @(negedge clk) begin
    op_t o;
    logic [W:0] fs;
    if (rst) begin
      k = 0;
      prev_done = 0;
    end else begin
      if (busy) begin
        if (q.size() == 0) chk("busy_without_op", 1, 0);
        else begin
          o = q[0];
          chk("add_a", add_a, o.a[4*k +: 4]);
          chk("add_b", add_b, beff(o) >> (4*k) & 4'hF);
          chk("add_cin", add_cin, carry_into(o, k));
          k++;
        end
      end else begin
        chk("idle_add_bus", {add_a, add_b, add_cin}, 0);
      end
      if (done) begin
        chk("done_width", prev_done, 0);
        chk("busy_in_done", busy, 0);
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          o = q.pop_front();
          fs = full_sum(o);
          chk("busy_cycles", k, N);
          chk("result", result, fs[W-1:0]);
          chk("cout", cout, fs[W]);
        end
        k = 0;
      end
      prev_done = done;
    end
  end

  task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic c, logic s);
    int n = 0;
    logic se;
    @(negedge clk);
    while ((busy || done) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("idle_timeout", 1, 0);
`ifdef NSA_SUB_EN
    se = s;
    sub = s;
`else
    se = 1'b0;
`endif
    op_a = a; op_b = b; cin_init = c; start = 1;
    q.push_back('{a: a, b: b, c: c, s: se});
    @(negedge clk);
    start = 0; op_a = W'($urandom); op_b = W'($urandom); cin_init = 1'($urandom);
`ifdef NSA_SUB_EN
    sub = 1'($urandom);
`endif
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_zero(string name);
    chk(name, {busy, done, cout, add_a, add_b, add_cin}, 0);
    chk({name, "_result"}, result, 0);
  endtask

  initial begin
    #200000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    #1 rst = 0;
    issue(16'h1234, 16'h5678, 0, 0);
    start = 1; op_a = 16'h0001; op_b = 16'h0001; cin_init = 0;
    wait_done();
    start = 0;
    chk("t1_result", result, 16'h68AC);
    chk("t1_cout", cout, 0);
    repeat (2) @(negedge clk);
    chk("t1_hold", result, 16'h68AC);
    issue(16'h0001, 16'h0001, 0, 0);
    wait_done();
    chk("one_plus_one", result, 16'h0002);
    issue(16'hFFFF, 16'h0001, 0, 0);
    wait_done();
    chk("ripple_result", result, 16'h0000);
    chk("ripple_cout", cout, 1);
    issue(16'hD5D5, 16'h3B3B, 1, 0);
    wait_done();
    chk("cin_result", result, 16'h1111);
    chk("cin_cout", cout, 1);
    issue(16'hABCD, 16'h1357, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1 chk_zero("abort");
    q.delete();
    @(negedge clk);
    #1 rst = 0;
    repeat (4) @(negedge clk);
    issue(16'h1234, 16'h1111, 0, 0);
    wait_done();
    chk("after_abort", result, 16'h2345);
`ifdef NSA_SUB_EN
    issue(16'h0005, 16'h0007, 0, 1);
    wait_done();
    chk("sub_neg_result", result, 16'hFFFE);
    chk("sub_neg_cout", cout, 0);
    issue(16'h0009, 16'h0004, 0, 1);
    wait_done();
    chk("sub_pos_result", result, 16'h0005);
    chk("sub_pos_cout", cout, 1);
`endif
    for (int i = 0; i < 20; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      wait_done();
    end
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
